// File: rtl/inst_prefetch_q_pkg.sv
// Shared types, helpers and bus-width defines for the instruction prefetch queue.
// The optional flush counter is enabled by defining IPQ_PERF_CNT_EN.
`ifndef IPQ_DEFINES_SVH
`define IPQ_DEFINES_SVH
`define InstAddrBus 31:0
`define InstBus 31:0
`define ResetPC 32'h0000_0000
`define WordInc 32'd4
`endif

package inst_prefetch_q_pkg;

  localparam int unsigned IpqEntryW = 64;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } ipq_entry_t;

  // Redirect targets are word addresses; the low byte-offset bits are dropped.
  function automatic logic [`InstAddrBus] ipq_align(input logic [`InstAddrBus] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ipq_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and combinational head.
// Storage is not reset; only pointers and count are.
module ipq_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;
  logic             empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

  // A pop frees the slot a simultaneous push writes, so push is legal when full.
  assign do_pop  = pop_i & ~empty & ~flush_i;
  assign do_push = push_i & (~full | do_pop) & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign valid_o = ~empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_q.sv
// Instruction prefetch queue: drives the ROM fetch port, buffers {pc, inst} pairs and presents
// the head to decode. Optional flush counter output when IPQ_PERF_CNT_EN is defined.
module inst_prefetch_q
  import inst_prefetch_q_pkg::*;
#(
  parameter int unsigned         DEPTH    = 4,
  parameter logic [`InstAddrBus] RESET_PC = `ResetPC
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rom_ce_o,
  output logic [`InstAddrBus]     rom_addr_o,
  input  logic [`InstBus]         rom_data_i,
  input  logic                    stall_i,
  input  logic                    ready_i,
  input  logic                    redirect_i,
  input  logic [`InstAddrBus]     redirect_addr_i,
  output logic                    inst_valid_o,
  output logic [`InstBus]         inst_o,
  output logic [`InstAddrBus]     inst_pc_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef IPQ_PERF_CNT_EN
  ,
  output logic [15:0]             flush_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [`InstAddrBus] fetch_pc_q, fetch_pc_d;
  logic                en_q;
  logic                push, pop;
  ipq_entry_t          wr_entry, head_entry;
  logic                fifo_valid, fifo_full;
  logic [CntW-1:0]     fifo_count;

  assign pop  = fifo_valid & ready_i & ~stall_i & ~redirect_i;
  assign push = en_q & ~redirect_i & (~fifo_full | pop);

  assign rom_ce_o   = push;
  assign rom_addr_o = fetch_pc_q;

  assign wr_entry = '{pc: fetch_pc_q, inst: rom_data_i};

  ipq_fifo #(
    .Width(IpqEntryW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i (wr_entry),
    .head_o  (head_entry),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = ipq_align(redirect_addr_i);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + `WordInc;
    end
  end

  // en_q holds fetch off for the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      en_q       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      en_q       <= 1'b1;
    end
  end

  assign inst_valid_o = fifo_valid;
  assign inst_o       = fifo_valid ? head_entry.inst : '0;
  assign inst_pc_o    = fifo_valid ? head_entry.pc : '0;
  assign count_o      = fifo_count;

`ifdef IPQ_PERF_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [16:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt_q} + 17'(fifo_count);

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect_i) begin
      flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_q.sv
// Bench for inst_prefetch_q: table of hand-derived checkpoints plus a per-cycle queue scoreboard.
module tb_inst_prefetch_q;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam logic [31:0] RomXor = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rom_ce;
  logic [31:0]     rom_addr;
  logic [31:0]     rom_data;
  logic            stall = 1'b0;
  logic            ready = 1'b1;
  logic            redirect = 1'b0;
  logic [31:0]     redirect_addr = '0;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [31:0]     inst_pc;
  logic [CntW-1:0] count;
`ifdef IPQ_PERF_CNT_EN
  logic [15:0]     flush_cnt;
`endif

  inst_prefetch_q #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .stall_i         (stall),
    .ready_i         (ready),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .inst_valid_o    (inst_valid),
    .inst_o          (inst),
    .inst_pc_o       (inst_pc),
    .count_o         (count)
`ifdef IPQ_PERF_CNT_EN
    ,
    .flush_cnt_o     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rom_data = rom_addr ^ RomXor;

  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: entries pushed when a fetch is expected, popped when decode consumes.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_en = 1'b0;
  logic [15:0] m_flush = 16'h0;
  bit          sb_on = 1'b0;

  always @(negedge clk) begin : monitor
    logic        ev, ep, eh;
    logic [31:0] epc, einst;
    int          sum;
    if (sb_on) begin
      ev    = (sb_q.size() > 0);
      epc   = ev ? sb_q[0].pc : 32'h0;
      einst = ev ? sb_q[0].inst : 32'h0;
      ep    = ev & ready & ~stall & ~redirect;
      eh    = m_en & ~redirect & ((sb_q.size() < DEPTH) | ep);
      check32("sb_rom_ce", 32'(rom_ce), 32'(eh));
      check32("sb_rom_addr", rom_addr, m_pc);
      check32("sb_valid", 32'(inst_valid), 32'(ev));
      check32("sb_inst", inst, einst);
      check32("sb_pc", inst_pc, epc);
      check32("sb_count", 32'(count), 32'(sb_q.size()));
`ifdef IPQ_PERF_CNT_EN
      check32("sb_flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
      if (rst) begin
        sb_q.delete();
        m_pc    = 32'h0;
        m_en    = 1'b0;
        m_flush = 16'h0;
      end else begin
        m_en = 1'b1;
        if (redirect) begin
          sum = int'(m_flush) + sb_q.size();
          m_flush = (sum > 65535) ? 16'hFFFF : 16'(sum);
          sb_q.delete();
          m_pc = {redirect_addr[31:2], 2'b00};
        end else begin
          if (ep) void'(sb_q.pop_front());
          if (eh) begin
            sb_q.push_back('{pc: m_pc, inst: m_pc ^ RomXor});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  typedef struct {
    logic        rst, ready, stall, redir;
    logic [31:0] raddr;
    int          cycles;
    logic [31:0] count;
    logic        valid;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] addr;
    logic [15:0] flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rd, logic st, logic rdr, logic [31:0] ra, int cyc,
                              logic [31:0] cnt, logic v, logic [31:0] pc, logic ce,
                              logic [31:0] addr, logic [15:0] fl);
    vec_t t;
    t.rst = r; t.ready = rd; t.stall = st; t.redir = rdr; t.raddr = ra; t.cycles = cyc;
    t.count = cnt; t.valid = v; t.pc = pc; t.ce = ce; t.addr = addr; t.flush = fl;
    return t;
  endfunction

  initial begin
    // rst rdy stl rdr raddr cyc | count valid pc ce addr flush
    vecs.push_back(mk(1, 1, 0, 0, 0, 2,   0, 0, 32'h0,  0, 32'h0,   0));  // reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 32'h0,  1, 32'h0,   0));  // first fetch enabled
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   1, 1, 32'h0,  1, 32'h4,   0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2,   1, 1, 32'h8,  1, 32'hC,   0));  // streaming
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 32'h0,  0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 32'h0,  1, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4,   4, 1, 32'h0,  0, 32'h10,  0));  // fill to full
    vecs.push_back(mk(0, 0, 0, 0, 0, 2,   4, 1, 32'h0,  0, 32'h10,  0));  // full holds
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   4, 1, 32'h0,  1, 32'h10,  0));  // push+pop when full
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   4, 1, 32'h4,  1, 32'h14,  0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 32'h0,  0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 32'h0,  1, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3,   3, 1, 32'h0,  1, 32'hC,   0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h103, 0, 3, 1, 32'h0, 0, 32'hC,  0));  // redirect asserted
    vecs.push_back(mk(0, 0, 0, 1, 32'h103, 1, 0, 0, 32'h0, 0, 32'h100, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 32'h0,  1, 32'h100, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 32'h0,  0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 32'h0,  1, 32'h0,   0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3,   1, 1, 32'h8,  1, 32'hC,   0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 3,   4, 1, 32'h8,  0, 32'h18,  0));  // stall fills queue
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   4, 1, 32'h8,  1, 32'h18,  0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   4, 1, 32'hC,  1, 32'h1C,  0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h200, 1, 0, 0, 32'h0, 0, 32'h0,  0));  // reset beats redirect
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 32'h0,  1, 32'h0,   0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   1, 1, 32'h0,  1, 32'h4,   0));

    fork
      begin
        @(posedge clk);
        sb_on = 1'b1;
      end
    join_none

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      ready         = vecs[i].ready;
      stall         = vecs[i].stall;
      redirect      = vecs[i].redir;
      redirect_addr = vecs[i].raddr;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check32($sformatf("v%0d_count", i), 32'(count), vecs[i].count);
      check32($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].valid));
      check32($sformatf("v%0d_pc", i), inst_pc, vecs[i].pc);
      check32($sformatf("v%0d_inst", i), inst, vecs[i].valid ? (vecs[i].pc ^ RomXor) : 32'h0);
      check32($sformatf("v%0d_rom_ce", i), 32'(rom_ce), 32'(vecs[i].ce));
      check32($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].addr);
`ifdef IPQ_PERF_CNT_EN
      check32($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].flush));
`endif
    end

    // Random traffic tracked by the scoreboard alone.
    for (int n = 0; n < 300; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      ready         = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = $urandom;
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    sb_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_q.md
Name: inst_prefetch_q

Overview:
Instruction prefetch queue between the instruction ROM and the MIPS core decode. It drives the ROM fetch port, buffers up to DEPTH fetched instructions together with their PCs, and presents the head entry to decode. It consumes the pipeline bubble signal from the hazard/bubble controller and flushes on taken branch or jump redirects.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
rom_ce_o  output  1  ROM chip enable; high only in a cycle that fetches.
rom_addr_o  output  32  ROM byte address; always equals fetch_pc.
rom_data_i  input  32  ROM instruction; combinational, valid in the same cycle as rom_addr_o.
stall_i  input  1  bubble from the hazard controller; when high, decode does not consume.
ready_i  input  1  decode can accept the head entry.
redirect_i  input  1  taken branch or jump; flush the queue and restart fetch.
redirect_addr_i  input  32  new fetch address; bits [1:0] ignored.
inst_valid_o  output  1  head entry valid.
inst_o  output  32  head instruction; 32'h0 when not valid.
inst_pc_o  output  32  PC of the head instruction; 32'h0 when not valid.
count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc <= RESET_PC; count <= 0; read and write pointers <= 0; en_q <= 0.
  - Outputs in the cycle after reset: rom_ce_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, count_o=0.
  - en_q goes to 1 on the first edge with rst=0. Fetching starts the cycle after that edge.
- pop = inst_valid_o & ready_i & ~stall_i & ~redirect_i.
- push = en_q & ~redirect_i & (count<DEPTH | pop).
- rom_ce_o = push. Combinational; rom_addr_o = fetch_pc at all times.
- On push:
  - The entry {fetch_pc, rom_data_i} is written at the tail.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
  - The entry becomes visible at the head no earlier than the next cycle. There is no same-cycle bypass, so fetch-to-decode latency is 1 cycle.
- On pop: the head advances, and the next entry is presented combinationally in the following cycle.
- Push and pop in the same cycle:
  - count is unchanged.
  - This is legal when full: the pop frees the slot the push writes.
- Full (count==DEPTH) with no pop: rom_ce_o=0 and fetch_pc holds.
- Empty: inst_valid_o=0. A stall has no effect on an empty queue.
- redirect_i=1:
  - No push and no pop in that cycle.
  - At the edge: count <= 0, pointers <= 0, fetch_pc <= {redirect_addr_i[31:2],2'b00}.
  - All queued entries are discarded.
  - The next cycle fetches from the new address.
- Priority: rst > redirect_i > pop/push.
- Reset mid-operation discards all entries. redirect_i is ignored while rst=1.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Head outputs are combinational from storage and the read pointer.
- The storage array itself is not reset. Only pointers, count and valid are.

Optional Feature:
- Macro: IPQ_PERF_CNT_EN.
- Defined:
  - Adds output flush_cnt_o (16 bits).
  - Each redirect adds the number of entries discarded, i.e. count at that edge.
  - The counter saturates at 16'hFFFF and is cleared by rst.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared defines file:
  - `InstAddrBus (31:0) and `InstBus (31:0).
  - `ResetPC, used as the RESET_PC default.
  - `WordInc (32'd4).
- One sub-module, ipq_fifo:
  - Generic synchronous FIFO parameterised on width and depth.
  - Provides push, pop, flush, count and head outputs.
  - Entry width is 64 bits ({pc, inst}).
- inst_prefetch_q contains fetch_pc, en_q, the push/pop/redirect control and the optional counter.

Test Plan:
1. Reset for 2 cycles, release, ready_i=1, stall_i=0, ROM returns addr^32'hA5A5_0000.
   -> First rom_ce_o=1 at addr 0x0 one cycle after release. inst_valid_o=1 the next cycle with inst_pc_o=0x0, inst_o=0xA5A5_0000. Then one instruction per cycle: 0x4, 0x8, ...
2. ready_i=0 from release.
   -> Four fetches at 0x0, 0x4, 0x8, 0xC. count_o=4, then rom_ce_o=0 with rom_addr_o held at 0x10.
3. Queue full, ready_i raised to 1.
   -> In the same cycle, pop of 0x0 and fetch of 0x10. count_o stays 4; the next head PC is 0x4.
4. Three entries queued; redirect_i=1 with redirect_addr_i=32'h0000_0103.
   -> Next cycle count_o=0, inst_valid_o=0, rom_addr_o=0x100, rom_ce_o=1. With IPQ_PERF_CNT_EN defined, flush_cnt_o=3.
5. Valid head at 0x8, ready_i=1, stall_i=1 for 3 cycles.
   -> No pop: inst_pc_o stays 0x8 throughout. Fetch continues until count_o=DEPTH. Pop resumes the first cycle stall_i=0.
6. rst=1 and redirect_i=1 (addr 0x200) in the same cycle.
   -> Reset wins: count_o=0, and after release the first fetch is at RESET_PC, not 0x200.
